// File: rtl/mem_ctrl_burst.sv
// Memory control FSM with separate read/write wait states, fixed-length bursts and a synchronous
// abort. All outputs are registers decoded from the next state, so nothing combinational leaks out.
module mem_ctrl_burst #(
  parameter int unsigned RD_WAIT   = 15,
  parameter int unsigned WR_WAIT   = 15,
  parameter int unsigned BEAT_WAIT = 2,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned BEAT_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MStrobe,
  input  logic              MemWrite,
  input  logic              BurstEn,
  input  logic              Abort,
  output logic              PReady,
  output logic              Busy,
  output logic              MemCmd,
  output logic              MemRW,
  output logic [BEAT_W-1:0] BeatCnt
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2,
    StData  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              rw_q, rw_d;
  logic              burst_q, burst_d;

  logic              p_ready_q, busy_q, mem_cmd_q, mem_rw_q;
  logic [BEAT_W-1:0] beat_cnt_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    beat_d  = beat_q;
    rw_d    = rw_q;
    burst_d = burst_q;
    case (state_q)
      StIdle: begin
        if (MStrobe) begin
          rw_d    = MemWrite;
          burst_d = BurstEn;
          beat_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        count_d = rw_q ? CNT_W'(WR_WAIT) : CNT_W'(RD_WAIT);
        state_d = StWait;
      end
      StWait: begin
        if (count_q == CNT_W'(1)) begin
          state_d = StData;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      StData: begin
        if (burst_q && (beat_q < BEAT_W'(BURST_LEN - 1))) begin
          beat_d  = beat_q + BEAT_W'(1);
          count_d = CNT_W'(BEAT_WAIT);
          state_d = StWait;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Abort overrides every transition out of a busy state
    if ((state_q != StIdle) && Abort) begin
      state_d = StIdle;
      count_d = '0;
      beat_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      beat_q     <= '0;
      rw_q       <= 1'b0;
      burst_q    <= 1'b0;
      p_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      mem_cmd_q  <= 1'b0;
      mem_rw_q   <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      beat_q     <= beat_d;
      rw_q       <= rw_d;
      burst_q    <= burst_d;
      p_ready_q  <= (state_d == StData);
      busy_q     <= (state_d != StIdle);
      mem_cmd_q  <= (state_d == StStart);
      mem_rw_q   <= (state_d != StIdle) && rw_d;
      beat_cnt_q <= (state_d == StData) ? beat_d : '0;
    end
  end

  assign PReady  = p_ready_q;
  assign Busy    = busy_q;
  assign MemCmd  = mem_cmd_q;
  assign MemRW   = mem_rw_q;
  assign BeatCnt = beat_cnt_q;

endmodule

// File: tb/tb_mem_ctrl_burst.sv
// Bench for mem_ctrl_burst: transaction table plus scoreboard of expected beats, and hand-written
// sequences for reset, back-to-back strobes and distinct read/write waits.
module tb_mem_ctrl_burst;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       MStrobe, MemWrite, BurstEn, Abort;
  logic       PReady, Busy, MemCmd, MemRW;
  logic [1:0] BeatCnt;

  logic       b_strobe, b_write, b_burst, b_abort;
  logic       b_pready, b_busy, b_cmd, b_rw;
  logic [1:0] b_beat;

  int tests      = 0;
  int fails      = 0;
  int cyc        = 0;
  int seen_beats = 0;

  always @(posedge clk) cyc <= cyc + 1;

  mem_ctrl_burst u_dut (
    .clk      (clk),
    .reset    (reset),
    .MStrobe  (MStrobe),
    .MemWrite (MemWrite),
    .BurstEn  (BurstEn),
    .Abort    (Abort),
    .PReady   (PReady),
    .Busy     (Busy),
    .MemCmd   (MemCmd),
    .MemRW    (MemRW),
    .BeatCnt  (BeatCnt)
  );

  mem_ctrl_burst #(
    .RD_WAIT (3),
    .WR_WAIT (7)
  ) u_dut_b (
    .clk      (clk),
    .reset    (reset),
    .MStrobe  (b_strobe),
    .MemWrite (b_write),
    .BurstEn  (b_burst),
    .Abort    (b_abort),
    .PReady   (b_pready),
    .Busy     (b_busy),
    .MemCmd   (b_cmd),
    .MemRW    (b_rw),
    .BeatCnt  (b_beat)
  );

  typedef struct {
    int         cyc;
    logic [1:0] beat;
    logic       rw;
  } beat_t;

  beat_t exp_q[$];

  typedef struct {
    logic rw;
    logic burst;
    int   abort_off;  // cycle offset from the START cycle at which Abort is driven, -1 = none
    logic abort_idle; // Abort raised together with the strobe while still idle
    int   exp_busy;
    int   exp_beats;
  } vec_t;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Scoreboard: every PReady pops the oldest expected beat and checks its timing and content
  always @(negedge clk) begin
    if (!reset && PReady === 1'b1) begin
      seen_beats++;
      check("beat_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_cycle", cyc, e.cyc);
        check("beat_index", BeatCnt, e.beat);
        check("beat_rw", MemRW, e.rw);
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int    t0;
    int    n;
    int    busy_cnt;
    int    rw_bad;
    int    cmd_cnt;
    int    beats0;
    int    nbeats;
    beat_t e;
    @(negedge clk);
    MStrobe  = 1'b1;
    MemWrite = v.rw;
    BurstEn  = v.burst;
    Abort    = v.abort_idle;
    @(negedge clk);
    t0      = cyc;
    MStrobe = 1'b0;
    Abort   = 1'b0;
    beats0  = seen_beats;
    nbeats  = v.burst ? 4 : 1;
    for (int k = 0; k < nbeats; k++) begin
      e.cyc  = t0 + 16 + 3 * k;
      e.beat = 2'(k);
      e.rw   = v.rw;
      if (v.abort_off < 0 || e.cyc <= t0 + v.abort_off) exp_q.push_back(e);
    end
    busy_cnt = 0;
    rw_bad   = 0;
    cmd_cnt  = 0;
    n        = 0;
    while (Busy === 1'b1 && n < 300) begin
      busy_cnt++;
      if (MemRW !== v.rw) rw_bad++;
      if (MemCmd === 1'b1) cmd_cnt++;
      MemWrite = ~MemWrite;
      BurstEn  = ~BurstEn;
      Abort    = (v.abort_off >= 0) && (cyc == t0 + v.abort_off);
      @(negedge clk);
      n++;
    end
    Abort    = 1'b0;
    MemWrite = 1'b0;
    BurstEn  = 1'b0;
    check($sformatf("v%0d_busy_len", idx), busy_cnt, v.exp_busy);
    check($sformatf("v%0d_memrw_held", idx), rw_bad, 0);
    check($sformatf("v%0d_cmd_pulses", idx), cmd_cnt, 1);
    check($sformatf("v%0d_beats", idx), seen_beats - beats0, v.exp_beats);
    check($sformatf("v%0d_beats_left", idx), exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs[10];
    int    t0;
    int    n;
    int    rw_bad;
    beat_t e;

    //         rw    burst  abort  idleAb busy beats
    vecs[0] = '{1'b0, 1'b0, -1,    1'b0,  17,  1};
    vecs[1] = '{1'b1, 1'b1, -1,    1'b0,  26,  4};
    vecs[2] = '{1'b0, 1'b1, 10,    1'b0,  11,  0};
    vecs[3] = '{1'b1, 1'b0, -1,    1'b0,  17,  1};
    vecs[4] = '{1'b0, 1'b1, -1,    1'b0,  26,  4};
    vecs[5] = '{1'b1, 1'b0, 16,    1'b0,  17,  1};
    vecs[6] = '{1'b0, 1'b0, 0,     1'b0,  1,   0};
    vecs[7] = '{1'b1, 1'b1, 19,    1'b0,  20,  2};
    vecs[8] = '{1'b0, 1'b1, 17,    1'b0,  18,  1};
    vecs[9] = '{1'b0, 1'b0, -1,    1'b1,  17,  1};

    reset    = 1'b1;
    MStrobe  = 1'b0;
    MemWrite = 1'b0;
    BurstEn  = 1'b0;
    Abort    = 1'b0;
    b_strobe = 1'b0;
    b_write  = 1'b0;
    b_burst  = 1'b0;
    b_abort  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", Busy, 0);
    check("rst_pready", PReady, 0);
    check("rst_memcmd", MemCmd, 0);
    check("rst_memrw", MemRW, 0);
    check("rst_beatcnt", BeatCnt, 0);
    reset = 1'b0;

    // Reset asserted mid-WAIT clears outputs without a clock edge
    @(negedge clk);
    MStrobe  = 1'b1;
    MemWrite = 1'b1;
    @(negedge clk);
    MStrobe = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", Busy, 1);
    check("pre_rst_memrw", MemRW, 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_busy", Busy, 0);
    check("async_rst_memrw", MemRW, 0);
    check("async_rst_pready", PReady, 0);
    check("async_rst_memcmd", MemCmd, 0);
    @(negedge clk);
    reset    = 1'b0;
    MemWrite = 1'b0;
    exp_q.delete();

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Strobe held high through a read; MemWrite toggling is ignored, next request after one idle
    @(negedge clk);
    MStrobe  = 1'b1;
    MemWrite = 1'b0;
    BurstEn  = 1'b0;
    @(negedge clk);
    t0     = cyc;
    e.cyc  = t0 + 16;
    e.beat = 2'd0;
    e.rw   = 1'b0;
    exp_q.push_back(e);
    rw_bad = 0;
    n      = 0;
    while (Busy === 1'b1 && n < 100) begin
      if (MemRW !== 1'b0) rw_bad++;
      MemWrite = ~MemWrite;
      @(negedge clk);
      n++;
    end
    check("b2b_rw_held", rw_bad, 0);
    check("b2b_idle_at", cyc - t0, 17);
    MemWrite = 1'b1;
    @(negedge clk);
    check("b2b_second_cmd", MemCmd, 1);
    check("b2b_second_start", cyc - t0, 18);
    check("b2b_second_rw", MemRW, 1);
    e.cyc = t0 + 18 + 16;
    e.rw  = 1'b1;
    exp_q.push_back(e);
    MStrobe  = 1'b0;
    MemWrite = 1'b0;
    n        = 0;
    while (Busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done_at", cyc - t0, 18 + 17);
    check("b2b_beats_left", exp_q.size(), 0);
    exp_q.delete();

    // Distinct read and write waits on the second instance
    @(negedge clk);
    b_strobe = 1'b1;
    b_write  = 1'b0;
    @(negedge clk);
    t0       = cyc;
    b_strobe = 1'b0;
    n        = 0;
    while (b_pready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rdwait_first_beat", cyc - t0, 4);
    check("rdwait_rw", b_rw, 0);
    n = 0;
    while (b_busy === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    b_strobe = 1'b1;
    b_write  = 1'b1;
    @(negedge clk);
    t0       = cyc;
    b_strobe = 1'b0;
    b_write  = 1'b0;
    n        = 0;
    while (b_pready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wrwait_first_beat", cyc - t0, 8);
    check("wrwait_rw", b_rw, 1);
    n = 0;
    while (b_busy === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wrwait_busy_len", cyc - t0, 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
